// File: rtl/chunked_subtractor.sv
// chunked_subtractor
//   Multi-cycle SIZE-bit subtractor: Result = A - B - Bin, with borrow-out,
//   zero and signed-overflow flags. It handles CHUNK bits per clock, least
//   significant chunk first, and ripples a borrow from one chunk to the next.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             operation request
//   A, B, Bin         minuend, subtrahend, borrow-in (sampled at acceptance)
//   ready             high while idle
//   done              one-cycle completion pulse
//   Result            A - B - Bin mod 2^SIZE
//   Bout              1 iff unsigned A < B + Bin
//   Zero              1 iff Result == 0
//   Overflow          1 iff the signed difference does not fit in SIZE bits
//   state_dbg         current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a request is taken on a rising edge where start && ready.
// Nothing is queued, so start while ready==0 is dropped. done is high for
// exactly one cycle. Result and the flags are valid from that cycle and
// hold until the next completion.
module chunked_subtractor #(
   parameter int SIZE  = 32,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] A,
   input  logic [SIZE-1:0] B,
   input  logic            Bin,
   output logic            ready,
   output logic            done,
   output logic [SIZE-1:0] Result,
   output logic            Bout,
   output logic            Zero,
   output logic            Overflow,
   output logic [1:0]      state_dbg
);

   localparam int N  = SIZE / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   generate
      if (SIZE % CHUNK != 0) begin : g_bad_chunk
         $error("chunked_subtractor: SIZE must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Working registers
   logic [SIZE-1:0] a_q, b_q, res_q;
   logic            borrow_q;
   logic [IW-1:0]   idx_q;

   // Output registers: these change only on the final chunk, so the outputs
   // never show a partial result.
   logic [SIZE-1:0] result_q;
   logic            bout_q, zero_q, ovf_q;

   // Datapath for the current chunk
   int              base;
   logic [CHUNK-1:0] a_sl, b_sl;
   logic [CHUNK:0]   sub;
   logic [SIZE-1:0]  res_full;
   logic             ovf_full;

   always_comb begin
      base     = int'(idx_q) * CHUNK;
      a_sl     = a_q[base +: CHUNK];
      b_sl     = b_q[base +: CHUNK];
      // The extra top bit of the difference is the borrow out of this chunk.
      sub      = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, borrow_q};
      res_full = res_q;
      res_full[base +: CHUNK] = sub[CHUNK-1:0];
      // Sign rule: overflow when the operand signs differ and the result sign
      // differs from A. This matches (borrow into MSB) XOR (borrow out of MSB).
      ovf_full = (a_q[SIZE-1] ^ b_q[SIZE-1]) & (res_full[SIZE-1] ^ a_q[SIZE-1]);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BUSY;
         S_BUSY:  if (idx_q == LAST_IDX) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Working and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q      <= A;
                  b_q      <= B;
                  res_q    <= '0;
                  borrow_q <= Bin;
                  idx_q    <= '0;
               end
            end
            S_BUSY: begin
               res_q    <= res_full;
               borrow_q <= sub[CHUNK];
               if (idx_q == LAST_IDX) begin
                  idx_q    <= '0;
                  result_q <= res_full;
                  bout_q   <= sub[CHUNK];
                  zero_q   <= (res_full == '0);
                  ovf_q    <= ovf_full;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE);
   assign Result    = result_q;
   assign Bout      = bout_q;
   assign Zero      = zero_q;
   assign Overflow  = ovf_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
module tb_chunked_subtractor;

   localparam int SIZE  = 32;
   localparam int CHUNK = 8;
   localparam int N     = SIZE / CHUNK;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [SIZE-1:0] A, B;
   logic            Bin;
   logic            ready, done;
   logic [SIZE-1:0] Result;
   logic            Bout, Zero, Overflow;
   logic [1:0]      state_dbg;

   always #5 clk = ~clk;

   chunked_subtractor #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .A(A), .B(B), .Bin(Bin),
      .ready(ready), .done(done),
      .Result(Result), .Bout(Bout), .Zero(Zero), .Overflow(Overflow),
      .state_dbg(state_dbg)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Packed as {Overflow, Zero, Bout, Result}.
   function automatic logic [SIZE+2:0] ref_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                              input logic bin);
      logic [SIZE:0] full;
      longint        sr;
      logic          ov;
      full = {1'b0, a} - {1'b0, b} - {{SIZE{1'b0}}, bin};
      sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      ov   = (sr < -(longint'(1) <<< (SIZE-1))) || (sr > (longint'(1) <<< (SIZE-1)) - 1);
      return {ov, (full[SIZE-1:0] == '0), full[SIZE], full[SIZE-1:0]};
   endfunction

   // ---------------- scoreboard ----------------
   // Timing model: accept at edge k, done visible after edge k+N, ready back
   // after edge k+N+1. Outputs hold the last completed result.
   logic [SIZE+2:0] exp_q[$];
   bit              m_ready = 1'b1;
   bit              m_done  = 1'b0;
   logic [SIZE+2:0] m_out   = '0;
   int              m_cnt   = 0;
   int              m_due   = 0;
   bit              chk_en  = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_ready = 1'b1;
            m_done  = 1'b0;
            m_out   = '0;
            exp_q.delete();
         end else begin
            m_cnt++;
            if (m_done) begin
               m_done  = 1'b0;
               m_ready = 1'b1;
            end else if (m_ready && start) begin
               exp_q.push_back(ref_op(A, B, Bin));
               m_ready = 1'b0;
               m_due   = m_cnt + N;
            end else if (!m_ready && m_cnt == m_due) begin
               m_done = 1'b1;
               m_out  = exp_q.pop_front();
            end
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("sb_ready", ready, m_ready);
            chk("sb_done", done, m_done);
            chk("sb_outputs", {Overflow, Zero, Bout, Result}, m_out);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin);
      @(negedge clk);
      #1;
      A = a; B = b; Bin = bin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits for done; exp_lat counts rising edges from the current point.
   task automatic wait_done(input string nm, input int exp_lat, input logic [SIZE-1:0] er,
                            input logic ebo, input logic ez, input logic eov);
      int lat;
      bit got;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 50) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else begin
            chk({nm, "_ready_low"}, ready, 1'b0);
            @(posedge clk);
            lat++;
         end
      end
      chk({nm, "_done_seen"}, got, 1'b1);
      if (got) begin
         chk({nm, "_latency"}, lat, exp_lat);
         chk({nm, "_result"}, {Overflow, Zero, Bout, Result}, {eov, ez, ebo, er});
      end
   endtask

   task automatic run_op(input string nm, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic bin, input logic [SIZE-1:0] er,
                         input logic ebo, input logic ez, input logic eov);
      issue(a, b, bin);
      wait_done(nm, N, er, ebo, ez, eov);
   endtask

   function automatic logic [SIZE-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   int nd;
   int ndone;
   int last;

   initial begin
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", ready, 1'b1);
      chk("reset_done", done, 1'b0);
      chk("reset_outputs", {Overflow, Zero, Bout, Result}, '0);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // Literal vectors
      run_op("small",      32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
      run_op("xchunk",     32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
      run_op("wrap",       32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_op("ovf_neg",    32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
      run_op("ovf_pos",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
      run_op("zero_bin",   32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
      run_op("bin_only",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_op("bin_ovf",    32'h8000_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);

      // start during BUSY is ignored
      issue(32'h0000_00A0, 32'h0000_0020, 1'b0);
      @(negedge clk);
      #1;
      A = 32'hFFFF_FFFF; B = 32'h0000_0001; Bin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("ignore_start", N - 1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-BUSY
      issue(32'h0000_000A, 32'h0000_0003, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_ready", ready, 1'b1);
      chk("async_rst_done", done, 1'b0);
      chk("async_rst_outputs", {Overflow, Zero, Bout, Result}, '0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("no_done_after_reset", nd, 0);

      // Back-to-back with start held high
      ndone = 0;
      last  = -1;
      @(negedge clk);
      #1;
      A = pick(); B = pick(); Bin = 1'($urandom_range(0, 1)); start = 1'b1;
      for (int c = 0; c < 200 * (N + 2) + 20 && ndone < 200; c++) begin
         @(negedge clk);
         if (done) begin
            if (last >= 0) chk("b2b_spacing", c - last, N + 2);
            last = c;
            ndone++;
         end
         #1;
         A = pick(); B = pick(); Bin = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      chk("b2b_count", ndone, 200);
      repeat (N + 4) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
